line_delay_ctrl: RTL

- Controller directly upstream/downstream of the 8-bit, 2048-deep synchronous prefetch FIFO used as a one-line delay in the HDMI video pipeline.
- Writes the incoming pixel stream into the FIFO and reads back the pixel from the previous line at the same column.
- Presents each current pixel together with its vertically adjacent pixel to the 2-row filter stage.
- Tracks line length, frame boundaries and FIFO occupancy, and drains the FIFO at end of frame.

---
 rtl/line_delay_if.sv | 47 ++++
 rtl/line_delay_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/line_delay_if.sv
// Bundles the pixel-in stream, the FIFO port and the pixel-pair output of line_delay_ctrl.
// slave = controller view, master = environment (source, FIFO, sink) view.
interface line_delay_if #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 11
);
    // Streams use valid/ready: a beat moves on a clk edge where in_vld & in_rdy;
    // the FIFO moves on fifo_wr_en / fifo_rd_en alone; out_vld is a one-cycle strobe.
    logic              in_vld;
    logic [DATA_W-1:0] in_data;
    logic              in_eol;
    logic              in_eof;
    logic              in_rdy;

    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_wr_vld;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_vld;

    logic              out_vld;
    logic [DATA_W-1:0] out_cur;
    logic [DATA_W-1:0] out_prev;
    logic              out_first;
    logic              out_eol;
    logic              out_eof;
    logic              err_len;
    logic              err_ovf;

    logic [2:0]        dbg_state;
    logic [COL_W:0]    dbg_occ;

    modport slave (
        input  in_vld, in_data, in_eol, in_eof, fifo_wr_vld, fifo_rd_data, fifo_rd_vld,
        output in_rdy, fifo_wr_en, fifo_wr_data, fifo_rd_en,
        output out_vld, out_cur, out_prev, out_first, out_eol, out_eof, err_len, err_ovf,
        output dbg_state, dbg_occ
    );

    modport master (
        output in_vld, in_data, in_eol, in_eof, fifo_wr_vld, fifo_rd_data, fifo_rd_vld,
        input  in_rdy, fifo_wr_en, fifo_wr_data, fifo_rd_en,
        input  out_vld, out_cur, out_prev, out_first, out_eol, out_eof, err_len, err_ovf,
        input  dbg_state, dbg_occ
    );
endinterface

// File: rtl/line_delay_ctrl.sv
// One-line delay controller around a prefetch FIFO: pairs each pixel with the pixel above it.
// Optional macro LINE_DELAY_EDGE_REPLICATE_EN: replicate current pixel when no line above exists.
module line_delay_ctrl #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 11,
    parameter int DEPTH  = 2048
) (
    input  logic         clk,
    input  logic         rst_n,
    line_delay_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        SKIP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [COL_W:0] ONE     = {{COL_W{1'b0}}, 1'b1};
    localparam logic [COL_W:0] OCC_MAX = DEPTH[COL_W:0];

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [COL_W:0]    line_len;
    logic [COL_W:0]    skip_cnt;
    logic [COL_W:0]    occ;
    logic [COL_W:0]    col_nxt;
    logic              in_rdy;
    logic              acc;
    logic              in_fill;
    logic              can_read;
    logic              rd_en;
    logic [DATA_W-1:0] edge_val;

    assign col_nxt  = {1'b0, col} + ONE;
    assign in_rdy   = bus.fifo_wr_vld & (state != DRAIN) & (state != SKIP);
    assign acc      = bus.in_vld & in_rdy;
    assign in_fill  = (state == IDLE) | (state == FILL);
    assign can_read = (state == RUN) & bus.fifo_rd_vld & ({1'b0, col} < line_len);

`ifdef LINE_DELAY_EDGE_REPLICATE_EN
    assign edge_val = bus.in_data;
`else
    assign edge_val = '0;
`endif

    always_comb begin
        rd_en = 1'b0;
        case (state)
            RUN:     rd_en = acc & can_read;
            SKIP:    rd_en = bus.fifo_rd_vld & (skip_cnt != '0);
            DRAIN:   rd_en = bus.fifo_rd_vld;
            default: rd_en = 1'b0;
        endcase
    end

    assign bus.in_rdy       = in_rdy;
    assign bus.fifo_wr_en   = acc;
    assign bus.fifo_wr_data = bus.in_data;
    assign bus.fifo_rd_en   = rd_en;
    assign bus.dbg_state    = state;
    assign bus.dbg_occ      = occ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            col           <= '0;
            line_len      <= '0;
            skip_cnt      <= '0;
            occ           <= '0;
            bus.out_vld   <= 1'b0;
            bus.out_cur   <= '0;
            bus.out_prev  <= '0;
            bus.out_first <= 1'b0;
            bus.out_eol   <= 1'b0;
            bus.out_eof   <= 1'b0;
            bus.err_len   <= 1'b0;
            bus.err_ovf   <= 1'b0;
        end else begin
            // Simultaneous write and read leave occupancy unchanged.
            if (acc && !rd_en && occ != OCC_MAX)
                occ <= occ + ONE;
            else if (!acc && rd_en && occ != '0)
                occ <= occ - ONE;

            bus.out_vld <= acc;
            if (acc) begin
                bus.out_cur   <= bus.in_data;
                bus.out_prev  <= can_read ? bus.fifo_rd_data : edge_val;
                bus.out_first <= in_fill;
                bus.out_eol   <= bus.in_eol;
                bus.out_eof   <= bus.in_eof;
            end

            if (bus.in_vld && !in_rdy)
                bus.err_ovf <= 1'b1;

            case (state)
                IDLE, FILL: begin
                    if (acc) begin
                        if (bus.in_eol) begin
                            line_len <= col_nxt;
                            col      <= '0;
                            state    <= bus.in_eof ? DRAIN : RUN;
                        end else begin
                            col   <= col_nxt[COL_W-1:0];
                            state <= FILL;
                        end
                    end
                end
                RUN: begin
                    if (acc) begin
                        if (!can_read)
                            bus.err_len <= 1'b1;
                        if (bus.in_eol) begin
                            col <= '0;
                            if (col_nxt < line_len)
                                bus.err_len <= 1'b1;
                            // A short line leaves stale entries of the line above; flush them.
                            if (bus.in_eof)
                                state <= DRAIN;
                            else if (col_nxt < line_len) begin
                                skip_cnt <= line_len - col_nxt;
                                state    <= SKIP;
                            end
                        end else begin
                            col <= col_nxt[COL_W-1:0];
                        end
                    end
                end
                SKIP: begin
                    if (rd_en) begin
                        skip_cnt <= skip_cnt - ONE;
                        if (skip_cnt == ONE)
                            state <= RUN;
                    end else begin
                        state <= RUN;
                    end
                end
                DRAIN: begin
                    if (occ == '0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
